ov7670_frame_writer: RTL and testbench

OV7670_FRAME_WRITER -- requirements
Module: ov7670_frame_writer

---
 rtl/ov7670_frame_writer_pkg.sv | 20 ++
 rtl/ov7670_frame_writer_pixel_fifo.sv | 67 ++++++
 rtl/ov7670_frame_writer.sv | 142 ++++++++++++++
 tb/tb_ov7670_frame_writer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_frame_writer_pkg.sv
// Shared definitions for the OV7670 camera capture blocks: FSM state
// encoding, default frame geometry and datapath widths.
package ov7670_frame_writer_pkg;

    // 240 x 240 RGB565 frame.
    localparam int unsigned FRAME_PIXELS_DEFAULT = 57600;
    localparam int unsigned FIFO_DEPTH_DEFAULT   = 8;

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned ADDR_W = 16;

    // Capture FSM encoding, kept as plain constants so older tools and
    // scripts that decode the state register keep working.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/ov7670_frame_writer_pixel_fifo.sv
// Single-clock pixel FIFO sitting between the camera side and the RAM
// write port. Pointers carry one extra wrap bit so full and empty are
// distinguishable without a separate occupancy counter. A push while full
// is accepted when a pop happens in the same cycle.
module pixel_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Next pointer values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array write.
    // NOTE: the array is deliberately not reset; empty pointers make its
    // contents unobservable, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ov7670_frame_writer.sv
// Captures one OV7670 frame per start pulse and streams the accepted
// pixels into RAM at consecutive addresses through a small FIFO. Flags
// report dropped pixels (FIFO full) and frames cut short by VSYNC.
module ov7670_frame_writer
    import ov7670_frame_writer_pkg::*;
#(
    parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic              main_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              new_img,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              ram_ready,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              short_frame
);

    localparam logic [15:0] FRAME_LAST = 16'(FRAME_PIXELS - 1);

    logic [2:0]        state_q, state_d;
    logic              new_img_q;
    logic [15:0]       pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              overflow_q, overflow_d;
    logic              short_q, short_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [PIX_W-1:0]  fifo_head;
    logic              push;
    logic              pop;
    logic              vs_rise;
    logic              vs_fall;
    logic              frame_complete;

    // The RAM side always presents the FIFO head; a transfer pops it.
    assign pop  = !fifo_empty && ram_ready;
    // A full FIFO still takes a pixel when the head leaves in the same cycle.
    assign push = (state_q == ST_CAPTURE) && pix_valid && (!fifo_full || pop);

    assign vs_rise        = new_img && !new_img_q;
    assign vs_fall        = !new_img && new_img_q;
    assign frame_complete = push && (pix_cnt_q == FRAME_LAST);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_pixel_fifo (
        .clk     (main_clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (pix_data),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Capture FSM, pixel counter, write address and sticky flags.
    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        wr_addr_d  = wr_addr_q;
        overflow_d = overflow_q;
        short_d    = short_q;

        if (pop) wr_addr_d = wr_addr_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ARMED;
                    pix_cnt_d  = '0;
                    wr_addr_d  = '0;
                    overflow_d = 1'b0;
                    short_d    = 1'b0;
                end
            end
            ST_ARMED: begin
                if (vs_fall) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (push) pix_cnt_d = pix_cnt_q + 16'd1;
                if (pix_valid && !push) overflow_d = 1'b1;
                if (frame_complete) begin
                    state_d = ST_DRAIN;
                end else if (vs_rise) begin
                    // Any push in this cycle is already kept above.
                    short_d = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Empty FIFO means no write is still being presented.
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            new_img_q  <= 1'b0;
            pix_cnt_q  <= '0;
            wr_addr_q  <= '0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            new_img_q  <= new_img;
            pix_cnt_q  <= pix_cnt_d;
            wr_addr_q  <= wr_addr_d;
            overflow_q <= overflow_d;
            short_q    <= short_d;
        end
    end

    assign ram_wr      = !fifo_empty;
    assign ram_addr    = wr_addr_q;
    // Gate the head so the data bus reads zero whenever nothing is presented.
    assign ram_wdata   = fifo_empty ? '0 : fifo_head;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = (state_q == ST_DONE);
    assign overflow    = overflow_q;
    assign short_frame = short_q;

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Self-checking bench for ov7670_frame_writer. A behavioural model (queue
// of pending pixels plus frame bookkeeping) predicts every RAM write and
// flag; the DUT is checked on every falling clock edge.
module tb_ov7670_frame_writer;

    localparam int FRAME = 1500;
    localparam int DEPTH = 8;

    logic        main_clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        new_img;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        ram_ready;
    logic        ram_wr;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic        short_frame;

    always #5 main_clk = ~main_clk;

    ov7670_frame_writer #(
        .FRAME_PIXELS (FRAME),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .main_clk    (main_clk),
        .reset_n     (reset_n),
        .start       (start),
        .new_img     (new_img),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .ram_ready   (ram_ready),
        .ram_wr      (ram_wr),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .short_frame (short_frame)
    );

    int vectors    = 0;
    int miscompares = 0;
    int obs_done   = 0;

    // Reference model
    typedef enum {M_IDLE, M_ARMED, M_CAPTURE, M_DRAIN, M_DONE} mstate_e;
    mstate_e     m_state;
    logic [15:0] m_q[$];
    int          m_addr;
    int          m_count;
    bit          m_ovf;
    bit          m_short;
    bit          m_prev_vs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = M_IDLE;
        m_q.delete();
        m_addr    = 0;
        m_count   = 0;
        m_ovf     = 1'b0;
        m_short   = 1'b0;
        m_prev_vs = 1'b0;
    endtask

    // Assert reset mid-cycle, check outputs clear at once, release after an edge.
    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        new_img   = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        ram_ready = 1'b1;
        #2;
        chk("rst_ram_wr",      ram_wr,      0);
        chk("rst_ram_addr",    ram_addr,    0);
        chk("rst_ram_wdata",   ram_wdata,   0);
        chk("rst_busy",        busy,        0);
        chk("rst_frame_done",  frame_done,  0);
        chk("rst_overflow",    overflow,    0);
        chk("rst_short_frame", short_frame, 0);
        @(posedge main_clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive, check on the falling edge, advance the model.
    task automatic cycle(input bit v, input logic [15:0] d, input bit rdy,
                         input bit vs, input bit st);
        bit pop;
        bit room;
        bit was_empty;
        bit accepted;
        pix_valid = v;
        pix_data  = d;
        ram_ready = rdy;
        new_img   = vs;
        start     = st;
        @(negedge main_clk);
        chk("ram_wr", ram_wr, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("ram_addr",  ram_addr,  m_addr);
            chk("ram_wdata", ram_wdata, m_q[0]);
        end
        chk("busy",        busy,        m_state != M_IDLE);
        chk("frame_done",  frame_done,  m_state == M_DONE);
        chk("overflow",    overflow,    m_ovf);
        chk("short_frame", short_frame, m_short);
        if (frame_done === 1'b1) obs_done++;

        was_empty = (m_q.size() == 0);
        pop       = !was_empty && rdy;
        room      = (m_q.size() < DEPTH) || pop;
        accepted  = 1'b0;
        if (pop) begin
            void'(m_q.pop_front());
            m_addr++;
        end
        case (m_state)
            M_IDLE: if (st) begin
                m_state = M_ARMED;
                m_ovf   = 1'b0;
                m_short = 1'b0;
                m_count = 0;
                m_addr  = 0;
            end
            M_ARMED: if (m_prev_vs && !vs) m_state = M_CAPTURE;
            M_CAPTURE: begin
                if (v && room) begin
                    m_q.push_back(d);
                    m_count++;
                    accepted = 1'b1;
                end else if (v) begin
                    m_ovf = 1'b1;
                end
                if (accepted && m_count == FRAME) begin
                    m_state = M_DRAIN;
                end else if (vs && !m_prev_vs) begin
                    m_short = 1'b1;
                    m_state = M_DRAIN;
                end
            end
            M_DRAIN: if (was_empty) m_state = M_DONE;
            default: m_state = M_IDLE;
        endcase
        m_prev_vs = vs;
        @(posedge main_clk);
        #1;
    endtask

    task automatic vsync();
        cycle(0, 16'h0, 1, 1, 0);
        cycle(0, 16'h0, 1, 1, 0);
        cycle(0, 16'h0, 1, 0, 0);
    endtask

    // Run with ready high until the model is back in IDLE, then one more cycle.
    task automatic finish_frame();
        for (int n = 0; n < 4 * FRAME && m_state != M_IDLE; n++)
            cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        chk("idle_after_frame", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          rdy;
        bit          v;
        int          frames_before;

        model_reset();
        do_reset();

        // Pixels before start are ignored.
        repeat (20) cycle(1'($urandom), 16'($urandom), 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 1);
        chk("busy_armed", busy, 1);
        // Pixels while armed are ignored.
        repeat (10) cycle(1, 16'($urandom), 1, 0, 0);
        vsync();
        // Full frame, data = index, a stray start mid-frame.
        for (int i = 0; i < FRAME; i++)
            cycle(1, 16'(i), 1, 0, (i == 700));
        finish_frame();
        chk("full_end_addr", ram_addr,    FRAME);
        chk("full_overflow", overflow,    0);
        chk("full_short",    short_frame, 0);
        chk("full_frames",   obs_done,    1);

        // Burst of 12 pixels with RAM stalled: 8 kept, 4 dropped.
        cycle(0, 16'h0, 1, 0, 1);
        vsync();
        for (int i = 0; i < 12; i++)
            cycle(1, 16'($urandom), 0, 0, 0);
        chk("burst_overflow", overflow, 1);
        chk("burst_no_pop",   ram_addr, 0);
        repeat (10) cycle(0, 16'h0, 1, 0, 0);
        chk("burst_written", ram_addr, 8);
        cycle(0, 16'h0, 1, 1, 0);
        finish_frame();
        chk("burst_short",  short_frame, 1);
        chk("burst_frames", obs_done,    2);

        // Short frame: VSYNC rises after 1000 pixels.
        cycle(0, 16'h0, 1, 0, 1);
        vsync();
        for (int i = 0; i < 1000; i++)
            cycle(1, 16'($urandom), 1, 0, 0);
        cycle(0, 16'h0, 1, 1, 0);
        finish_frame();
        chk("short_flag",     short_frame, 1);
        chk("short_end_addr", ram_addr,    1000);
        chk("short_frames",   obs_done,    3);

        // VSYNC rise coincident with a push: that pixel is kept.
        cycle(0, 16'h0, 1, 0, 1);
        vsync();
        for (int i = 0; i < 20; i++)
            cycle(1, 16'($urandom), 1, 0, 0);
        cycle(1, 16'hBEEF, 1, 1, 0);
        finish_frame();
        chk("rise_push_end_addr", ram_addr,    21);
        chk("rise_push_short",    short_frame, 1);

        // Reset around pixel 500 with random RAM stalls.
        frames_before = obs_done;
        cycle(0, 16'h0, 1, 0, 1);
        vsync();
        while (m_count < 500) begin
            rdy = 1'($urandom);
            v   = (m_q.size() < DEPTH) || (rdy && m_q.size() > 0);
            cycle(v, 16'($urandom), rdy, 0, 0);
        end
        do_reset();
        repeat (20) cycle(1'($urandom), 16'($urandom), 1, 0, 0);
        chk("reset_no_done", obs_done, frames_before);

        // Fresh frame after reset: 50% ready, FIFO kept near full.
        cycle(0, 16'h0, 1, 0, 1);
        vsync();
        for (int n = 0; n < 20 * FRAME && m_count < FRAME; n++) begin
            rdy = 1'($urandom);
            v   = ($urandom_range(0, 7) != 0) &&
                  ((m_q.size() < DEPTH) || (rdy && m_q.size() > 0));
            cycle(v, 16'($urandom), rdy, 0, 0);
        end
        finish_frame();
        chk("rand_end_addr", ram_addr,    FRAME);
        chk("rand_overflow", overflow,    0);
        chk("rand_short",    short_frame, 0);
        chk("rand_frames",   obs_done,    frames_before + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
